// File: rtl/walk_mem_pkg.sv
// Shared types and limits for the page-table walk memory responder.
// Holds the responder state encoding and the legal LATENCY range.
package walk_mem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Wide enough for the largest preload value, LATENCY_MAX-2.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } walk_state_e;

endpackage

// File: rtl/walk_mem_array.sv
// Descriptor word store for the walk responder.
// One synchronous write port and one registered read port with write-first bypass.
module walk_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // rd_data only moves on rd_en, so it holds the word captured at acceptance.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
        end
    end

endmodule

// File: rtl/walk_mem_responder.sv
// Fixed-latency read responder serving page-table descriptors to a table walker.
// Optional WALK_MEM_FAULT_EN adds out_ram_fault and range-checks reads and writes.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request accepted, counting down to the response cycle
//   RESP  | out_ram_valid pulse, out_ram_data carries the response
module walk_mem_responder
    import walk_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_ram_ren,
    input  logic [31:0] in_ram_addr,
    output logic        out_ram_ready,
    output logic        out_ram_valid,
    output logic [31:0] out_ram_data,
    input  logic        in_wr_en,
    input  logic [31:0] in_wr_addr,
    input  logic [31:0] in_wr_data
`ifdef WALK_MEM_FAULT_EN
    ,
    output logic        out_ram_fault
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
        $error("walk_mem_responder: LATENCY outside 1..15");
    end

    walk_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             wr_go;
    logic             rd_fault;
    logic             wr_fault;
    logic             fault_q;
    logic [31:0]      rd_word;
    logic [31:0]      resp_word;
    logic [31:0]      held_q;
    logic             unused_addr;

`ifdef WALK_MEM_FAULT_EN
    localparam logic [32:0] BYTE_LIMIT = 33'(longint'(DEPTH) * 4);

    assign rd_fault    = ({1'b0, in_ram_addr} >= BYTE_LIMIT);
    assign wr_fault    = ({1'b0, in_wr_addr} >= BYTE_LIMIT);
    assign unused_addr = ^{in_ram_addr[1:0], in_wr_addr[1:0]};
`else
    // Upper address bits are dropped, so accesses wrap modulo the array size.
    assign rd_fault    = 1'b0;
    assign wr_fault    = 1'b0;
    assign unused_addr = ^{in_ram_addr[31:AW+2], in_ram_addr[1:0],
                           in_wr_addr[31:AW+2], in_wr_addr[1:0]};
`endif

    assign accept = (state_q == IDLE) && in_ram_ren && !in_rst;
    assign wr_go  = in_wr_en && !in_rst && !wr_fault;

    walk_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (in_clk),
        .wr_en   (wr_go),
        .wr_idx  (in_wr_addr[AW+1:2]),
        .wr_data (in_wr_data),
        .rd_en   (accept),
        .rd_idx  (in_ram_addr[AW+1:2]),
        .rd_data (rd_word)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                fault_q <= rd_fault;
            end
            if (state_q == RESP) begin
                held_q <= resp_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_ram_ren) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are gated by in_rst so they read zero for the whole reset window.
    assign resp_word     = fault_q ? '0 : rd_word;
    assign out_ram_ready = (state_q == IDLE) && !in_rst;
    assign out_ram_valid = (state_q == RESP) && !in_rst;
    assign out_ram_data  = in_rst ? '0 : (out_ram_valid ? resp_word : held_q);

`ifdef WALK_MEM_FAULT_EN
    assign out_ram_fault = out_ram_valid && fault_q;
`endif

endmodule

// File: tb/tb_walk_mem_responder.sv
// Directed bench for walk_mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
// Expectations follow WALK_MEM_FAULT_EN when the bench is built with it.
module tb_walk_mem_responder;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        ren, ren1;
    logic [31:0] addr, addr1;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        ready, valid, ready1, valid1;
    logic [31:0] data, data1;
`ifdef WALK_MEM_FAULT_EN
    logic        fault, fault1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 in_clk = ~in_clk;

    walk_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_ram_ren    (ren),
        .in_ram_addr   (addr),
        .out_ram_ready (ready),
        .out_ram_valid (valid),
        .out_ram_data  (data),
        .in_wr_en      (wr_en),
        .in_wr_addr    (wr_addr),
        .in_wr_data    (wr_data)
`ifdef WALK_MEM_FAULT_EN
        ,
        .out_ram_fault (fault)
`endif
    );

    walk_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_ram_ren    (ren1),
        .in_ram_addr   (addr1),
        .out_ram_ready (ready1),
        .out_ram_valid (valid1),
        .out_ram_data  (data1),
        .in_wr_en      (wr_en),
        .in_wr_addr    (wr_addr),
        .in_wr_data    (wr_data)
`ifdef WALK_MEM_FAULT_EN
        ,
        .out_ram_fault (fault1)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        f;
        string       nm;
    } vec_t;

    vec_t vecs[6];

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_fault(input string nm, input logic exp);
`ifdef WALK_MEM_FAULT_EN
        chk(nm, 32'(fault), 32'(exp));
`else
        if (exp) chk(nm, 32'd0, 32'd1);
`endif
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Accept at edge k, expect the pulse in cycle k+2 only, data held in k+3.
    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic ef,
                           input string nm);
        chk({nm, " ready_pre"}, 32'(ready), 32'd1);
        ren = 1'b1; addr = a;
        cyc();
        ren = 1'b0; addr = '0;
        chk({nm, " valid_k1"}, 32'(valid), 32'd0);
        chk({nm, " ready_k1"}, 32'(ready), 32'd0);
        cyc();
        chk({nm, " valid_k2"}, 32'(valid), 32'd1);
        chk({nm, " ready_k2"}, 32'(ready), 32'd0);
        chk({nm, " data_k2"}, data, ed);
        chk_fault({nm, " fault_k2"}, ef);
        cyc();
        chk({nm, " valid_k3"}, 32'(valid), 32'd0);
        chk({nm, " ready_k3"}, 32'(ready), 32'd1);
        chk({nm, " data_hold"}, data, ed);
        chk_fault({nm, " fault_k3"}, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int pulses;

        vecs[0] = '{32'h0000_0040, 32'h0000_1001, 1'b0, "rd_40"};
        vecs[1] = '{32'h0000_0043, 32'h0000_1001, 1'b0, "rd_43"};
        vecs[2] = '{32'h0000_0044, 32'h0000_2002, 1'b0, "rd_44"};
        vecs[3] = '{32'h0000_0FFC, 32'hFFFF_0FFC, 1'b0, "rd_ffc"};
`ifdef WALK_MEM_FAULT_EN
        vecs[4] = '{32'h0000_1000, 32'h0000_0000, 1'b1, "rd_1000"};
        vecs[5] = '{32'h0000_0008, 32'h0000_0888, 1'b0, "rd_8"};
`else
        vecs[4] = '{32'h0000_1000, 32'hA0A0_0000, 1'b0, "rd_1000"};
        vecs[5] = '{32'h0000_0008, 32'h5555_1008, 1'b0, "rd_8"};
`endif

        in_rst = 1'b1; ren = 1'b0; ren1 = 1'b0; addr = '0; addr1 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cyc();
        cyc();
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst data", data, 32'd0);
        chk("rst ready1", 32'(ready1), 32'd0);
        chk_fault("rst fault", 1'b0);
        in_rst = 1'b0;
        #1;
        chk("post_rst ready", 32'(ready), 32'd1);

        wr(32'h0000_0000, 32'hA0A0_0000);
        wr(32'h0000_0008, 32'h0000_0888);
        wr(32'h0000_0040, 32'h0000_1001);
        wr(32'h0000_0044, 32'h0000_2002);
        wr(32'h0000_0FFC, 32'hFFFF_0FFC);
        wr(32'h0000_1008, 32'h5555_1008);

        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i].a, vecs[i].d, vecs[i].f, vecs[i].nm);
        end

        // Same-cycle write bypass, then a later write must not disturb the response.
        chk("byp ready_pre", 32'(ready), 32'd1);
        ren = 1'b1; addr = 32'h0000_0082;
        wr_en = 1'b1; wr_addr = 32'h0000_0080; wr_data = 32'hDEAD_BEEF;
        cyc();
        ren = 1'b0;
        wr_data = 32'h0000_1234;
        chk("byp valid_k1", 32'(valid), 32'd0);
        cyc();
        wr_en = 1'b0;
        chk("byp valid_k2", 32'(valid), 32'd1);
        chk("byp data_k2", data, 32'hDEAD_BEEF);
        cyc();
        chk("byp data_hold", data, 32'hDEAD_BEEF);
        do_read(32'h0000_0080, 32'h0000_1234, 1'b0, "rd_80_late");

        // Reset during WAIT, with a write attempted under reset.
        ren = 1'b1; addr = 32'h0000_0044;
        cyc();
        ren = 1'b0;
        in_rst = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h0000_0040; wr_data = 32'hBAD0_BAD0;
        #1;
        chk("midrst ready", 32'(ready), 32'd0);
        chk("midrst valid", 32'(valid), 32'd0);
        chk("midrst data", data, 32'd0);
        cyc();
        chk("midrst2 valid", 32'(valid), 32'd0);
        chk("midrst2 data", data, 32'd0);
        chk_fault("midrst2 fault", 1'b0);
        cyc();
        in_rst = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rel ready", 32'(ready), 32'd1);
        chk("rel valid", 32'(valid), 32'd0);
        chk("rel data", data, 32'd0);
        cyc();
        chk("rel2 valid", 32'(valid), 32'd0);
        do_read(32'h0000_0040, 32'h0000_1001, 1'b0, "rd_40_after_rst");

        // LATENCY=1 with ren held high: accept every other cycle.
        acc = 0;
        pulses = 0;
        ren1 = 1'b1; addr1 = 32'h0000_0040;
        for (int i = 0; i < 8; i++) begin
            chk("l1 ready", 32'(ready1), 32'((i % 2) == 0));
            chk("l1 valid", 32'(valid1), 32'((i % 2) == 1));
            if ((i % 2) == 1) chk("l1 data", data1, 32'h0000_1001);
            if (ready1 && ren1) acc++;
            if (valid1) pulses++;
            cyc();
        end
        ren1 = 1'b0;
        chk("l1 accepts", 32'(acc), 32'd4);
        chk("l1 pulses", 32'(pulses), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/walk_mem_responder.md
WALK_MEM_RESPONDER -- requirements
Module: walk_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words in the page-table store.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port in_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port in_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_ram_ren  input  1  read request from the table walker.
REQ-006 SHALL have port in_ram_addr  input  32  byte address of the descriptor to read.
REQ-007 SHALL have port out_ram_ready  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port out_ram_valid  output  1  one-cycle pulse marking out_ram_data valid.
REQ-009 SHALL have port out_ram_data  output  32  descriptor word returned.
REQ-010 SHALL have port in_wr_en  input  1  preload/update write strobe.
REQ-011 SHALL have port in_wr_addr  input  32  byte address of the write.
REQ-012 SHALL have port in_wr_data  input  32  word to write.
REQ-013 SHALL have port out_ram_fault  output  1  out-of-range response flag (present only under WALK_MEM_FAULT_EN).

Function
REQ-014 SHALL accept a request on a rising edge where in_ram_ren=1 and out_ram_ready=1; in_ram_ren while not ready is ignored, and the walker holds it.
REQ-015 SHALL form the word index as in_ram_addr[log2(DEPTH)+1:2]; in_ram_addr[1:0] are ignored.
REQ-016 SHALL use states IDLE (ready=1), WAIT (ready=0, down-counter), and RESP (ready=0, valid=1).
REQ-017 SHALL move IDLE->RESP on acceptance when LATENCY=1, else IDLE->WAIT with counter=LATENCY-2.
REQ-018 SHALL move WAIT->RESP when the counter is 0, else decrement the counter; RESP->IDLE unconditionally.
REQ-019 SHALL assert out_ram_valid in exactly the LATENCY-th cycle after the accepting edge, for exactly one cycle.
REQ-020 SHALL sample the array word at the accepting edge; later writes do not alter the pending response.
REQ-021 SHALL give write-first bypass: a write in the same cycle as acceptance, to the same word index, makes the response return in_wr_data.
REQ-022 SHALL perform writes in any state, one word per cycle, independent of the read path.
REQ-023 SHALL hold out_ram_data at its last response value outside RESP cycles.
REQ-024 SHALL make minimum request spacing LATENCY+1 cycles, with ready returning the cycle after the valid pulse.

Reset
REQ-025 SHALL, while in_rst=1, force state to IDLE, out_ram_ready=0, out_ram_valid=0, out_ram_data=0, out_ram_fault=0, and counter=0.
REQ-026 SHALL, on reset asserted mid-transaction, abandon the pending response with no valid pulse, and assert ready in the first cycle after in_rst falls.
REQ-027 SHALL NOT reset memory contents; in_wr_en is ignored while in_rst=1.

Configuration
REQ-028 SHALL, with WALK_MEM_FAULT_EN defined and in_ram_addr >= 4*DEPTH, return out_ram_data=0 with out_ram_fault=1 in the RESP cycle, and drop writes with in_wr_addr >= 4*DEPTH.
REQ-029 SHALL, with WALK_MEM_FAULT_EN undefined, omit out_ram_fault and wrap addresses modulo 4*DEPTH for both reads and writes.

Structure
REQ-030 SHALL place the state enum (IDLE/WAIT/RESP) and the LATENCY bounds in shared package walk_mem_pkg.
REQ-031 SHALL implement storage in sub-module walk_mem_array: one synchronous write port and one read port with write-first bypass.

Verification
REQ-032 SHALL cover: preload word 0x0000_1001 at address 0x40, LATENCY=2, request 0x40 at edge k -> valid=1 with data 0x0000_1001 in cycle k+2 only, ready=0 in cycles k+1..k+2.
REQ-033 SHALL cover: in_ram_ren held high continuously at LATENCY=1 -> accepts every 2 cycles, one valid pulse per acceptance.
REQ-034 SHALL cover: write 0xDEAD_BEEF to 0x80 in the same cycle a read of 0x82 is accepted -> response is 0xDEAD_BEEF; a write of 0x1234 one cycle later does not change that response.
REQ-035 SHALL cover: in_rst pulsed during WAIT -> no valid pulse, all outputs 0 during reset, ready=1 in the cycle after release.
REQ-036 SHALL cover: read of 0x1000 with DEPTH=1024 -> with WALK_MEM_FAULT_EN, fault=1 and data=0; without it, returns the word at 0x0.
